bsearch_ctrl: RTL and testbench

Sequencer that runs a binary search over a sorted, ascending RAM of DATA_W-bit words. It uses the 8-bit magnitude comparator as its datapath.
- The controller latches a search key and drives it onto the comparator's data_t input.
- It issues RAM read addresses; the RAM output feeds the comparator's ramout input directly.
- It samples the gt/eq/lt flags and narrows the search window until the key is found or the window is exhausted.
- It sits between the host and the RAM + comparator pair, and owns the RAM read port while busy.

---
 rtl/bsearch_ctrl.sv | 152 +++++++++++++++
 tb/tb_bsearch_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bsearch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bsearch_ctrl
// Brief    : Binary-search sequencer over a sorted ascending synchronous RAM,
//            using an external magnitude comparator (gt/eq/lt) as datapath.
// Revision : 1.0 - initial release
// ============================================================================
module bsearch_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] key,
  output logic [DATA_W-1:0] data_t,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  input  logic              gt,
  input  logic              eq,
  input  logic              lt,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] result_addr,
  output logic              err
);

  localparam logic [ADDR_W-1:0] c_hi_max = '1;
  localparam logic [ADDR_W-1:0] c_one    = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CMP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_lo, r_hi, r_mid;
  logic [ADDR_W-1:0]   w_lo_nxt, w_hi_nxt, w_mid_nxt;
  logic [ADDR_W:0]     w_sum;
  logic [DATA_W-1:0]   r_data_t, w_data_t_nxt;
  logic                r_found, w_found_nxt;
  logic                r_err, w_err_nxt;
  logic [ADDR_W-1:0]   r_result_addr, w_result_nxt;
  logic                r_busy, r_done;
  logic                w_onehot;

  // Exactly one comparator flag must be set for a trustworthy compare.
  assign w_onehot = (gt ^ eq ^ lt) & ~(gt & eq & lt);

  // Next-state, window narrowing and result decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_data_t_nxt = r_data_t;
    w_found_nxt  = r_found;
    w_err_nxt    = r_err;
    w_result_nxt = r_result_addr;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_ISSUE;
          w_data_t_nxt = key;
          w_lo_nxt     = '0;
          w_hi_nxt     = c_hi_max;
          w_found_nxt  = 1'b0;
          w_err_nxt    = 1'b0;
        end
      end
      S_ISSUE: w_state_nxt = S_CMP;
      S_CMP: begin
        if (!w_onehot) begin
          w_err_nxt    = 1'b1;
          w_found_nxt  = 1'b0;
          w_result_nxt = r_mid;
          w_state_nxt  = S_DONE;
        end else if (eq) begin
          w_found_nxt  = 1'b1;
          w_result_nxt = r_mid;
          w_state_nxt  = S_DONE;
        end else if (gt) begin
          // Key lies above mid; stop if the window's top has been probed.
          if (r_mid == r_hi) begin
            w_found_nxt  = 1'b0;
            w_result_nxt = r_mid;
            w_state_nxt  = S_DONE;
          end else begin
            w_lo_nxt    = r_mid + c_one;
            w_state_nxt = S_ISSUE;
          end
        end else begin
          // Key lies below mid; stop if the window's bottom has been probed.
          if (r_mid == r_lo) begin
            w_found_nxt  = 1'b0;
            w_result_nxt = r_mid;
            w_state_nxt  = S_DONE;
          end else begin
            w_hi_nxt    = r_mid - c_one;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Extra sum bit keeps lo+hi from overflowing before the halving.
    w_sum     = {1'b0, w_lo_nxt} + {1'b0, w_hi_nxt};
    w_mid_nxt = w_sum[ADDR_W:1];
  end

  // State and datapath registers; reset aborts any search in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_lo          <= '0;
      r_hi          <= c_hi_max;
      r_mid         <= '0;
      r_data_t      <= '0;
      r_found       <= 1'b0;
      r_err         <= 1'b0;
      r_result_addr <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lo          <= w_lo_nxt;
      r_hi          <= w_hi_nxt;
      r_mid         <= w_mid_nxt;
      r_data_t      <= w_data_t_nxt;
      r_found       <= w_found_nxt;
      r_err         <= w_err_nxt;
      r_result_addr <= w_result_nxt;
      r_busy        <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_CMP);
      r_done        <= (w_state_nxt == S_DONE);
    end
  end

  // RAM port is decoded straight from registered state and mid.
  assign ram_re      = (r_state == S_ISSUE);
  assign ram_addr    = ((r_state == S_ISSUE) || (r_state == S_CMP)) ? r_mid : '0;
  assign data_t      = r_data_t;
  assign busy        = r_busy;
  assign done        = r_done;
  assign found       = r_found;
  assign result_addr = r_result_addr;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bsearch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsearch_ctrl
// Brief    : Self-checking bench for bsearch_ctrl with a synchronous RAM model,
//            a behavioural comparator and a reference binary-search model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsearch_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] key = '0;
  logic [DATA_W-1:0] data_t;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic              gt, eq, lt;
  logic              busy, done, found, err;
  logic [ADDR_W-1:0] result_addr;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ramout = '0;
  bit                force_bad = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  bsearch_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .data_t(data_t),
    .ram_addr(ram_addr), .ram_re(ram_re), .gt(gt), .eq(eq), .lt(lt),
    .busy(busy), .done(done), .found(found), .result_addr(result_addr), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data appears one cycle after the read enable.
  always @(posedge clk) if (ram_re) ramout <= mem[ram_addr];

  // Comparator, optionally forced into an illegal gt=eq=1 condition.
  assign gt = force_bad ? 1'b1 : (data_t >  ramout);
  assign eq = force_bad ? 1'b1 : (data_t == ramout);
  assign lt = force_bad ? 1'b0 : (data_t <  ramout);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: textbook binary search over the array with integer bounds.
  task automatic ref_search(input int k, output int n, output bit f, output int a);
    int lo = 0;
    int hi = DEPTH - 1;
    int mid;
    n = 0; f = 0; a = 0;
    forever begin
      mid = (lo + hi) / 2;
      n++;
      a = mid;
      if (int'(mem[mid]) == k) begin f = 1; break; end
      if (k > int'(mem[mid])) begin
        if (mid == hi) break;
        lo = mid + 1;
      end else begin
        if (mid == lo) break;
        hi = mid - 1;
      end
    end
  endtask

  // Caller sits at a negedge; requests a search, tracks it to done, checks result.
  task automatic do_search(input logic [7:0] k, input bit inject, input int exp_n,
                           input bit exp_f, input int exp_a, input bit exp_e,
                           output int waits);
    bit acc  = 0;
    bit seen = 0;
    int cyc;
    start = 1'b1;
    key   = k;
    waits = 0;
    while (!acc && waits < 4) begin
      @(negedge clk);
      waits++;
      if (busy) acc = 1;
    end
    check("accept", 32'(acc), 32'd1);
    start = 1'b0;
    key   = 8'($urandom);
    cyc   = 1;
    while (!seen && cyc < 40) begin
      if (inject && cyc == 3) begin start = 1'b1; key = 8'h3F; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("done_cycle", 32'(cyc), 32'(2 * exp_n + 1));
    check("found", 32'(found), 32'(exp_f));
    check("result_addr", 32'(result_addr), 32'(exp_a));
    check("err", 32'(err), 32'(exp_e));
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic model_search(input logic [7:0] k, input bit inject, output int waits);
    int n, a;
    bit f;
    ref_search(int'(k), n, f, a);
    do_search(k, inject, n, f, a, 1'b0, waits);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, base;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(2 * i + 1);

    repeat (2) @(negedge clk);
    check("rst_outputs", {data_t, ram_addr, ram_re, busy, done, found, result_addr, err}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed searches on the 2i+1 image.
    do_search(8'h1F, 0, 1, 1, 15, 0, w);
    check("idle_accept_wait", 32'(w), 32'd1);
    do_search(8'h01, 0, 5, 1, 0, 0, w);
    do_search(8'h40, 0, 6, 0, 31, 0, w);
    do_search(8'h02, 0, 5, 0, 0, 0, w);
    do_search(8'h00, 0, 5, 0, 0, 0, w);

    // Start while busy is ignored; back-to-back start accepted after done.
    do_search(8'h01, 1, 5, 1, 0, 0, w);
    do_search(8'h3F, 0, 1 + 5, 1, 31, 0, w);
    check("b2b_accept_wait", 32'(w), 32'd2);

    // Asynchronous reset during the third probe.
    @(negedge clk);
    start = 1'b1; key = 8'h01;
    @(negedge clk);
    start = 1'b0;
    check("rst_test_busy", 32'(busy), 32'd1);
    for (int c = 1; c < 5; c++) @(negedge clk);
    check("probe3_re", 32'(ram_re), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs",
             {data_t, ram_addr, ram_re, busy, done, found, result_addr, err}, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_done_in_rst", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done | busy), 32'd0);
    end

    // Illegal flags: gt and eq both high.
    force_bad = 1'b1;
    do_search(8'h10, 0, 1, 0, 15, 1, w);
    force_bad = 1'b0;
    @(negedge clk);
    check("err_held", 32'(err), 32'd1);

    // Randomised sorted images and keys against the reference model.
    for (int t = 0; t < 1000; t++) begin
      base = $urandom_range(0, 120);
      for (int i = 0; i < DEPTH; i++) begin
        base = base + $urandom_range(0, 4);
        mem[i] = (base > 255) ? 8'hFF : 8'(base);
      end
      if ($urandom_range(0, 1) == 1) model_search(mem[$urandom_range(0, DEPTH - 1)], 0, w);
      else model_search(8'($urandom), 0, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
